// File: rtl/sid_write_sequencer.sv
// ---------------------------------------------------------------------------
// sid_write_sequencer
//
// Buffered register-write engine for the SID host bus. Write requests
// (voice, addr, data) arrive on a ready/valid port and are queued in a FIFO.
// Each queued write is then replayed onto the SID bus as follows:
//   1. The fields are driven for SETUP_CYC cycles with the strobe low.
//   2. The strobe is held high for STROBE_CYC cycles.
//   3. The fields are held for GAP_CYC more cycles with the strobe low.
// While the queue is non-empty, writes stream back to back with no idle
// cycle between them.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   in_valid/ready  request handshake (ready = FIFO not full)
//   in_voice/addr/data  request fields
//   flush           discard every queued write that has not yet started
//   bus_voice/addr/data  SID bus fields (held between writes)
//   bus_strobe      SID write strobe, active high
//   busy            engine is working on a write
//   level           FIFO occupancy
//   write_done      one-cycle pulse as each write finishes its gap
//   done_count      completed writes, wraps 0xFFFF -> 0
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module sid_write_sequencer #(
   parameter int ADDR_W     = 3,
   parameter int VOICE_W    = 2,
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 8,
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int GAP_CYC    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [VOICE_W-1:0]       in_voice,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     flush,
   output logic [VOICE_W-1:0]       bus_voice,
   output logic [ADDR_W-1:0]        bus_addr,
   output logic [DATA_W-1:0]        bus_data,
   output logic                     bus_strobe,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     write_done,
   output logic [15:0]              done_count
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENT_W   = VOICE_W + ADDR_W + DATA_W;
   localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                            ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                            : ((STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC);
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [ENT_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   count_q, count_d;
   logic               in_ready_q, in_ready_d;

   // sequencer state and registered bus outputs
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ENT_W-1:0]   fields_q, fields_d;
   logic               strobe_q, strobe_d;
   logic               busy_q, busy_d;
   logic               write_done_q, write_done_d;
   logic [15:0]        done_count_q, done_count_d;

   logic               push_s;
   logic               pop_s;
   logic               fifo_empty_s;
   logic [ENT_W-1:0]   in_entry_s;
   logic [ENT_W-1:0]   head_s;

   assign in_entry_s   = {in_voice, in_addr, in_data};
   assign head_s       = mem_q[rd_ptr_q];
   assign fifo_empty_s = (count_q == {LVL_W{1'b0}});
   // a push coinciding with flush is dropped
   assign push_s       = in_valid && in_ready_q && !flush;

   // Sequencer next-state: pops the FIFO head and paces setup/strobe/gap
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fields_d     = fields_q;
      strobe_d     = 1'b0;
      write_done_d = 1'b0;
      done_count_d = done_count_q;
      pop_s        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // flush wins over the pop it would otherwise race with
            if (!fifo_empty_s && !flush) begin
               pop_s    = 1'b1;
               fields_d = head_s;
               state_d  = ST_SETUP;
               cnt_d    = CNT_W'(SETUP_CYC - 1);
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d  = ST_STROBE;
               cnt_d    = CNT_W'(STROBE_CYC - 1);
               strobe_d = 1'b1;
            end else begin
               cnt_d    = cnt_q - CNT_W'(1);
            end
         end
         ST_STROBE: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d  = ST_HOLD;
               cnt_d    = CNT_W'(GAP_CYC - 1);
            end else begin
               cnt_d    = cnt_q - CNT_W'(1);
               strobe_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               write_done_d = 1'b1;
               done_count_d = done_count_q + 16'd1;
               // streaming: chain straight into the next write's setup
               if (!fifo_empty_s && !flush) begin
                  pop_s    = 1'b1;
                  fields_d = head_s;
                  state_d  = ST_SETUP;
                  cnt_d    = CNT_W'(SETUP_CYC - 1);
               end else begin
                  state_d  = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // FIFO pointer/occupancy next-state; flush empties by snapping rd to wr
   always_comb begin
      if (flush) begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = wr_ptr_q;
         count_d  = {LVL_W{1'b0}};
      end else begin
         wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
         count_d  = count_q + LVL_W'(push_s) - LVL_W'(pop_s);
      end
      in_ready_d = (count_d != LVL_W'(DEPTH));
   end

   // FIFO entry storage (no reset needed; occupancy guards the contents)
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= in_entry_s;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= {LVL_W{1'b0}};
         in_ready_q   <= 1'b1;
         state_q      <= ST_IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         fields_q     <= {ENT_W{1'b0}};
         strobe_q     <= 1'b0;
         busy_q       <= 1'b0;
         write_done_q <= 1'b0;
         done_count_q <= 16'd0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         in_ready_q   <= in_ready_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fields_q     <= fields_d;
         strobe_q     <= strobe_d;
         busy_q       <= busy_d;
         write_done_q <= write_done_d;
         done_count_q <= done_count_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign level      = count_q;
   assign bus_voice  = fields_q[ENT_W-1 -: VOICE_W];
   assign bus_addr   = fields_q[DATA_W +: ADDR_W];
   assign bus_data   = fields_q[DATA_W-1:0];
   assign bus_strobe = strobe_q;
   assign busy       = busy_q;
   assign write_done = write_done_q;
   assign done_count = done_count_q;

endmodule
